operand_fetch_stage: RTL and testbench

- Pipeline stage directly upstream of execute and downstream of decode. Drives the register file read addresses and consumes its two read-data outputs. Writes back nothing itself.
- Keeps a scoreboard of destination registers with writes in flight, stalls decode on hazards, and bypasses same-cycle writeback data.
- Registers the resolved operands into a valid/ready output slot for execute.

---
 rtl/operand_fetch_stage.sv | 135 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Sits between decode and execute. It drives the register file read
//   addresses and resolves the two source operands, taking same-cycle
//   writeback data in preference to register file data. A scoreboard tracks
//   destination registers whose writes are still in flight. Decode is stalled
//   on read-after-write and write-after-write hazards. Resolved operands are
//   registered into a valid/ready slot for execute.
//
// Optional feature (macro OPERAND_FETCH_ZERO_REG_EN):
//   defined   - r0 reads as zero, is never marked pending, never causes a stall
//   undefined - r0 is an ordinary register
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_*                     instruction from decode (valid/ready handshake)
//   src_reg1/2, src_data1/2  register file read address / combinational data
//   wb_en, wb_reg, wb_data   writeback bus (also drives the register file)
//   flush                    squash the output slot
//   ex_*                     registered operand slot for execute (valid/ready)
//   pending                  scoreboard, bit n set = write to rn in flight

module operand_fetch_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int OPCODE_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OPCODE_WIDTH-1:0]      in_opcode,
    input  logic [DATA_WIDTH-1:0]        in_imm,
    input  logic [REG_ADDR_WIDTH-1:0]    in_src1,
    input  logic [REG_ADDR_WIDTH-1:0]    in_src2,
    input  logic                         in_use1,
    input  logic                         in_use2,
    input  logic [REG_ADDR_WIDTH-1:0]    in_dst,
    input  logic                         in_writes_dst,
    output logic [REG_ADDR_WIDTH-1:0]    src_reg1,
    output logic [REG_ADDR_WIDTH-1:0]    src_reg2,
    input  logic [DATA_WIDTH-1:0]        src_data1,
    input  logic [DATA_WIDTH-1:0]        src_data2,
    input  logic                         wb_en,
    input  logic [REG_ADDR_WIDTH-1:0]    wb_reg,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         flush,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [DATA_WIDTH-1:0]        ex_op_a,
    output logic [DATA_WIDTH-1:0]        ex_op_b,
    output logic [DATA_WIDTH-1:0]        ex_imm,
    output logic [OPCODE_WIDTH-1:0]      ex_opcode,
    output logic [REG_ADDR_WIDTH-1:0]    ex_dst,
    output logic                         ex_writes_dst,
    output logic [2**REG_ADDR_WIDTH-1:0] pending
);

    logic                        byp1, byp2;
    logic                        haz1, haz2, waw;
    logic                        wb_hits_dst;
    logic                        slot_free, fire;
    logic                        zero1, zero2, zero_dst;
    logic [DATA_WIDTH-1:0]       operand1, operand2;
    logic [2**REG_ADDR_WIDTH-1:0] pending_nxt;

`ifdef OPERAND_FETCH_ZERO_REG_EN
    assign zero1    = (in_src1 == '0);
    assign zero2    = (in_src2 == '0);
    assign zero_dst = (in_dst == '0);
`else
    assign zero1    = 1'b0;
    assign zero2    = 1'b0;
    assign zero_dst = 1'b0;
`endif

    assign src_reg1 = in_src1;
    assign src_reg2 = in_src2;

    assign byp1        = wb_en & (wb_reg == in_src1);
    assign byp2        = wb_en & (wb_reg == in_src2);
    assign wb_hits_dst = wb_en & (wb_reg == in_dst);

    assign operand1 = zero1 ? '0 : (byp1 ? wb_data : src_data1);
    assign operand2 = zero2 ? '0 : (byp2 ? wb_data : src_data2);

    // A pending source is fine when its value is arriving on writeback now.
    assign haz1 = in_use1 & pending[in_src1] & ~byp1 & ~zero1;
    assign haz2 = in_use2 & pending[in_src2] & ~byp2 & ~zero2;
    assign waw  = in_writes_dst & pending[in_dst] & ~wb_hits_dst & ~zero_dst;

    assign slot_free = ~ex_valid | ex_ready;
    assign in_ready  = slot_free & ~haz1 & ~haz2 & ~waw & ~flush;
    assign fire      = in_valid & in_ready;

    // Order matters: writeback clear, then issue set (wins on same index),
    // then release of a squashed slot's destination.
    always_comb begin
        pending_nxt = pending;
        if (wb_en)
            pending_nxt[wb_reg] = 1'b0;
        if (fire & in_writes_dst & ~zero_dst)
            pending_nxt[in_dst] = 1'b1;
        if (flush & ex_valid & ex_writes_dst)
            pending_nxt[ex_dst] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending       <= '0;
            ex_valid      <= 1'b0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_imm        <= '0;
            ex_opcode     <= '0;
            ex_dst        <= '0;
            ex_writes_dst <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (fire) begin
                ex_valid      <= 1'b1;
                ex_op_a       <= operand1;
                ex_op_b       <= operand2;
                ex_imm        <= in_imm;
                ex_opcode     <= in_opcode;
                ex_dst        <= in_dst;
                ex_writes_dst <= in_writes_dst;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int OW = 4;
    localparam int NR = 16;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [OW-1:0] in_opcode;
    logic [DW-1:0] in_imm;
    logic [AW-1:0] in_src1, in_src2, in_dst;
    logic          in_use1, in_use2, in_writes_dst;
    logic [AW-1:0] src_reg1, src_reg2;
    logic [DW-1:0] src_data1, src_data2;
    logic          wb_en;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          ex_valid, ex_ready;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [OW-1:0] ex_opcode;
    logic [AW-1:0] ex_dst;
    logic          ex_writes_dst;
    logic [NR-1:0] pending;

    operand_fetch_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_imm(in_imm),
        .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
        .in_dst(in_dst), .in_writes_dst(in_writes_dst),
        .src_reg1(src_reg1), .src_reg2(src_reg2), .src_data1(src_data1), .src_data2(src_data2),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_dst(ex_dst), .ex_writes_dst(ex_writes_dst),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Register file sitting beside the stage.
    logic [DW-1:0] rf [NR];
    assign src_data1 = rf[src_reg1];
    assign src_data2 = rf[src_reg2];
    always @(posedge clk) if (wb_en) rf[wb_reg] <= wb_data;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [OW-1:0] op;
        logic [AW-1:0] dst;
        logic          wd;
    } txn_t;

    txn_t          exp_q[$];
    logic [NR-1:0] mp;
    int            checks = 0;
    int            passed = 0;
    bit            zero_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_zero(input logic [AW-1:0] r);
        return zero_en && (r == '0);
    endfunction

    // Architectural value of a register as seen this cycle.
    function automatic logic [DW-1:0] reg_value(input logic [AW-1:0] r);
        if (is_zero(r)) return '0;
        if (wb_en && wb_reg == r) return wb_data;
        return rf[r];
    endfunction

    // Register whose write is still outstanding after this cycle's writeback.
    function automatic bit in_flight(input logic [AW-1:0] r);
        return mp[r] && !(wb_en && wb_reg == r) && !is_zero(r);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ex_valid"}, ex_valid, 0);
        chk({tag, "_ex_fields"}, {ex_op_a, ex_op_b, ex_imm, ex_opcode, ex_dst, ex_writes_dst}, 0);
        chk({tag, "_pending"}, pending, 0);
    endtask

    // Monitor: compares the presented slot against the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && ex_valid && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("ex_valid_extra", ex_valid, 0);
                end else begin
                    chk("ex_op_a", ex_op_a, exp_q[0].a);
                    chk("ex_op_b", ex_op_b, exp_q[0].b);
                    chk("ex_imm", ex_imm, exp_q[0].imm);
                    chk("ex_opcode", ex_opcode, exp_q[0].op);
                    chk("ex_dst_wd", {ex_dst, ex_writes_dst}, {exp_q[0].dst, exp_q[0].wd});
                    if (ex_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
`ifdef OPERAND_FETCH_ZERO_REG_EN
        zero_en = 1'b1;
`else
        zero_en = 1'b0;
`endif
        for (int i = 0; i < NR; i++) rf[i] = DW'($urandom);
        rst = 1'b0;
        in_valid = 0; in_opcode = 0; in_imm = 0; in_src1 = 0; in_src2 = 0;
        in_use1 = 0; in_use2 = 0; in_dst = 0; in_writes_dst = 0;
        wb_en = 0; wb_reg = 0; wb_data = 0; flush = 0; ex_ready = 0;
        mp = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            bit            occupied, exp_ready, fire;
            logic [NR-1:0] mp_nxt;
            int            cand[$];
            txn_t          t;

            @(negedge clk);
            if (cyc == NCYC / 2) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                exp_q.delete();
                mp = '0;
                in_valid = 0; flush = 0; wb_en = 0;
                @(negedge clk);
                rst = 1'b1;
                continue;
            end

            in_valid      = ($urandom % 4) != 0;
            in_opcode     = OW'($urandom);
            in_imm        = DW'($urandom);
            in_src1       = AW'($urandom_range(0, 7));
            in_src2       = AW'($urandom_range(0, 7));
            in_dst        = AW'($urandom_range(0, 7));
            in_use1       = ($urandom % 3) != 0;
            in_use2       = ($urandom % 2) != 0;
            in_writes_dst = ($urandom % 4) != 0;
            ex_ready      = ($urandom % 3) != 0;
            flush         = ($urandom % 20) == 0;
            wb_en         = ($urandom % 5) < 2;
            wb_data       = DW'($urandom);
            for (int r = 0; r < NR; r++) if (mp[r]) cand.push_back(r);
            if (cand.size() != 0 && ($urandom % 4) != 0)
                wb_reg = AW'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                wb_reg = AW'($urandom_range(0, 7));
            #1;

            occupied = exp_q.size() != 0;
            chk("ex_valid", ex_valid, occupied);
            chk("pending", pending, mp);
            chk("src_regs", {src_reg1, src_reg2}, {in_src1, in_src2});

            exp_ready = (!occupied || ex_ready)
                      && !(in_use1 && in_flight(in_src1))
                      && !(in_use2 && in_flight(in_src2))
                      && !(in_writes_dst && in_flight(in_dst))
                      && !flush;
            chk("in_ready", in_ready, exp_ready);
            fire = in_valid && exp_ready;

            mp_nxt = mp;
            if (wb_en) mp_nxt[wb_reg] = 1'b0;
            if (fire && in_writes_dst && !is_zero(in_dst)) mp_nxt[in_dst] = 1'b1;
            if (flush && occupied) begin
                if (exp_q[0].wd) mp_nxt[exp_q[0].dst] = 1'b0;
                void'(exp_q.pop_front());
            end
            if (fire) begin
                t.a   = reg_value(in_src1);
                t.b   = reg_value(in_src2);
                t.imm = in_imm;
                t.op  = in_opcode;
                t.dst = in_dst;
                t.wd  = in_writes_dst;
                exp_q.push_back(t);
            end
            mp = mp_nxt;
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
